// File: rtl/ad7324_pkg.sv
// Shared constants, control-register field positions and FSM encoding for the AD7324 emulator.
package ad7324_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_W     = 13;
    localparam int CTRL_W     = 12;

    localparam logic [1:0] REG_SEL_CTRL = 2'b00;
    localparam logic [1:0] SEQ_CONT     = 2'b11;

    localparam int ADD_HI = 10;
    localparam int ADD_LO = 9;
    localparam int SEQ_HI = 3;
    localparam int SEQ_LO = 2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ad7324_emulator_spi_edge_sync.sv
// Pin synchroniser with rise/fall detection on the synchronised copy.
module spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/ad7324_emulator.sv
// AD7324 SPI target emulator: returns channel words on DOUT, decodes control writes from DIN.
// Optional conversion noise via the AD7324_EMU_NOISE_EN macro.
module ad7324_emulator #(
    parameter int FRAME_BITS  = ad7324_pkg::FRAME_BITS,
    parameter int DATA_W      = ad7324_pkg::DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK20M,
    input  logic              RSTp,
    input  logic              SCLK,
    input  logic              CS_N,
    input  logic              DIN,
    output logic              DOUT,
    output logic              DOUT_OE,
    input  logic [DATA_W-1:0] CH0_DATA,
    input  logic [DATA_W-1:0] CH1_DATA,
    input  logic [DATA_W-1:0] CH2_DATA,
    input  logic [DATA_W-1:0] CH3_DATA,
    output logic [11:0]       CTRL_REG,
    output logic              FRAME_DONE,
    output logic              FRAME_ERR
);

    import ad7324_pkg::*;

    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_din_lvl, w_din_rise, w_din_fall;
    logic w_unused_edges;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .i_clk(CLK20M), .i_rst(RSTp), .i_pin(SCLK),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk(CLK20M), .i_rst(RSTp), .i_pin(CS_N),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .i_clk(CLK20M), .i_rst(RSTp), .i_pin(DIN),
        .o_level(w_din_lvl), .o_rise(w_din_rise), .o_fall(w_din_fall)
    );

    assign w_unused_edges = &{1'b0, w_sclk_lvl, w_sclk_rise, w_cs_lvl, w_din_rise, w_din_fall};

    state_t                  r_state, w_state_nxt;
    logic [FRAME_BITS-1:0]   r_tx, w_tx_nxt, w_tx_shl, w_word;
    logic [FRAME_BITS-2:0]   r_rx, w_rx_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]              r_ptr, w_ptr_nxt;
    logic [CTRL_W-1:0]       r_ctrl, w_ctrl_nxt, w_new_ctrl;
    logic                    r_dout, w_dout_nxt;
    logic                    r_oe, w_oe_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_err, w_err_nxt;
    logic                    w_is_wr;
    logic [DATA_W-1:0]       w_raw, w_sample;

    always_comb begin
        w_raw = CH0_DATA;
        case (r_ptr)
            2'd1:    w_raw = CH1_DATA;
            2'd2:    w_raw = CH2_DATA;
            2'd3:    w_raw = CH3_DATA;
            default: w_raw = CH0_DATA;
        endcase
    end

`ifdef AD7324_EMU_NOISE_EN
    logic [15:0]        r_lfsr;
    logic signed [DATA_W:0] w_sum;

    always_ff @(posedge CLK20M or posedge RSTp) begin
        if (RSTp)
            r_lfsr <= LFSR_SEED;
        else if (r_state == IDLE && w_cs_fall)
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    // Sum widened by one bit; disagreeing top bits flag overflow of the DATA_W range.
    always_comb begin
        w_sum = $signed({w_raw[DATA_W-1], w_raw}) + $signed({{(DATA_W-1){r_lfsr[1]}}, r_lfsr[1:0]});
        if (w_sum[DATA_W] != w_sum[DATA_W-1])
            w_sample = w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            w_sample = w_sum[DATA_W-1:0];
    end
`else
    assign w_sample = w_raw;
`endif

    assign w_word    = FRAME_BITS'({1'b0, r_ptr, w_sample});
    assign w_tx_shl  = {r_tx[FRAME_BITS-2:0], 1'b0};
    assign w_cnt_inc = r_cnt + 1'b1;

    // Receive register holds DIN[15:1] only; DIN[0] carries no control information.
    assign w_is_wr    = r_rx[FRAME_BITS-2] && (r_rx[FRAME_BITS-3:FRAME_BITS-4] == REG_SEL_CTRL);
    assign w_new_ctrl = r_rx[CTRL_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_ctrl_nxt  = r_ctrl;
        w_dout_nxt  = r_dout;
        w_oe_nxt    = r_oe;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                w_oe_nxt   = 1'b0;
                w_dout_nxt = 1'b0;
                if (w_cs_fall) begin
                    w_tx_nxt    = w_word;
                    w_dout_nxt  = w_word[FRAME_BITS-1];
                    w_oe_nxt    = 1'b1;
                    w_rx_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    w_err_nxt   = 1'b1;
                    w_oe_nxt    = 1'b0;
                    w_dout_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (w_sclk_fall) begin
                    if (w_cnt_inc < CNT_W'(FRAME_BITS))
                        w_rx_nxt = {r_rx[FRAME_BITS-3:0], w_din_lvl};
                    w_tx_nxt   = w_tx_shl;
                    w_dout_nxt = w_tx_shl[FRAME_BITS-1];
                    w_cnt_nxt  = w_cnt_inc;
                    if (w_cnt_inc == CNT_W'(FRAME_BITS))
                        w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_cs_rise) begin
                    w_done_nxt  = 1'b1;
                    w_oe_nxt    = 1'b0;
                    w_dout_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                    if (w_is_wr) begin
                        w_ctrl_nxt = w_new_ctrl;
                        w_ptr_nxt  = (w_new_ctrl[SEQ_HI:SEQ_LO] == SEQ_CONT) ? 2'd0
                                                                             : w_new_ctrl[ADD_HI:ADD_LO];
                    end else if (r_ctrl[SEQ_HI:SEQ_LO] == SEQ_CONT) begin
                        w_ptr_nxt = (r_ptr == r_ctrl[ADD_HI:ADD_LO]) ? 2'd0 : r_ptr + 2'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK20M or posedge RSTp) begin
        if (RSTp) begin
            r_state <= IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_ctrl  <= '0;
            r_dout  <= 1'b0;
            r_oe    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_dout  <= w_dout_nxt;
            r_oe    <= w_oe_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign DOUT       = r_dout;
    assign DOUT_OE    = r_oe;
    assign CTRL_REG   = r_ctrl;
    assign FRAME_DONE = r_done;
    assign FRAME_ERR  = r_err;

endmodule

// File: tb/tb_ad7324_emulator.sv
// Bench for ad7324_emulator: directed frame table, abort/reset sequences, random frames vs a rule model.
// Define AD7324_EMU_NOISE_EN on both RTL and bench to exercise the noise path.
module tb_ad7324_emulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, cs_n, din;
    logic        dout, dout_oe;
    logic [12:0] ch [4];
    logic [11:0] ctrl_reg;
    logic        frame_done, frame_err;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]  m_ptr;
    logic [11:0] m_ctrl;
    logic [15:0] m_lfsr;

    always #25 clk = ~clk;

    ad7324_emulator #(.FRAME_BITS(16), .DATA_W(13), .SYNC_STAGES(2)) dut (
        .CLK20M(clk), .RSTp(rst), .SCLK(sclk), .CS_N(cs_n), .DIN(din),
        .DOUT(dout), .DOUT_OE(dout_oe),
        .CH0_DATA(ch[0]), .CH1_DATA(ch[1]), .CH2_DATA(ch[2]), .CH3_DATA(ch[3]),
        .CTRL_REG(ctrl_reg), .FRAME_DONE(frame_done), .FRAME_ERR(frame_err)
    );

    typedef struct {
        logic [15:0] din;
        logic [12:0] c0, c1, c2, c3;
        logic [15:0] exp_word;
        logic [11:0] exp_ctrl;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_ptr  = 2'd0;
        m_ctrl = 12'h000;
        m_lfsr = 16'hACE1;
    endtask

    // Word the device should return for the frame starting now; advances the noise source.
    task automatic predict(output logic [15:0] w);
        logic [12:0] v;
        int          s, n;
        v = ch[m_ptr];
        s = 0;
        n = 0;
`ifdef AD7324_EMU_NOISE_EN
        n = m_lfsr[1] ? int'(m_lfsr[1:0]) - 4 : int'(m_lfsr[1:0]);
        s = int'($signed(v)) + n;
        if (s > 4095)  s = 4095;
        if (s < -4096) s = -4096;
        v = 13'(s);
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
        w = {1'b0, m_ptr, v};
    endtask

    task automatic model_commit(input logic [15:0] d);
        if (d[15] && d[14:13] == 2'b00) begin
            m_ctrl = d[12:1];
            m_ptr  = (m_ctrl[3:2] == 2'b11) ? 2'd0 : m_ctrl[10:9];
        end else if (m_ctrl[3:2] == 2'b11) begin
            m_ptr = (m_ptr == m_ctrl[10:9]) ? 2'd0 : m_ptr + 2'd1;
        end
    endtask

    task automatic run_frame(input logic [15:0] d, input int nfalls, input bit scramble,
                             output logic [15:0] word, output int ndone, output int nerr,
                             output bit oe_ok);
        word  = '0;
        ndone = 0;
        nerr  = 0;
        oe_ok = 1'b1;
        cs_n = 1'b0;
        cyc(8);
        for (int i = 0; i < nfalls; i++) begin
            din = d[15-i];
            cyc(8);
            word[15-i] = dout;
            if (!dout_oe) oe_ok = 1'b0;
            sclk = 1'b0;
            cyc(8);
            sclk = 1'b1;
            if (scramble && i == 0)
                for (int c = 0; c < 4; c++) ch[c] = 13'($urandom);
        end
        cyc(8);
        cs_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ndone += int'(frame_done);
            nerr  += int'(frame_err);
        end
        cyc(4);
    endtask

    vec_t        tbl [11];
    logic [15:0] w, exp_w, d;
    int          nd, ne;
    bit          ok;

    initial begin
        tbl[0]  = '{16'h0000, 13'h0123, 13'h0002, 13'h0003, 13'h1FFF, 16'h0123, 12'h000};
        tbl[1]  = '{16'h8C00, 13'h0123, 13'h0002, 13'h0003, 13'h1FFF, 16'h0123, 12'h600};
        tbl[2]  = '{16'h0000, 13'h0123, 13'h0002, 13'h0003, 13'h1FFF, 16'h7FFF, 12'h600};
        tbl[3]  = '{16'h0000, 13'h0123, 13'h0002, 13'h0003, 13'h1FFF, 16'h7FFF, 12'h600};
        tbl[4]  = '{16'h8818, 13'h0123, 13'h0002, 13'h0003, 13'h1FFF, 16'h7FFF, 12'h40C};
        tbl[5]  = '{16'h0000, 13'h0123, 13'h0002, 13'h0003, 13'h1FFF, 16'h0123, 12'h40C};
        tbl[6]  = '{16'h0000, 13'h0123, 13'h0002, 13'h0003, 13'h1FFF, 16'h2002, 12'h40C};
        tbl[7]  = '{16'h0000, 13'h0123, 13'h0002, 13'h0003, 13'h1FFF, 16'h4003, 12'h40C};
        tbl[8]  = '{16'h0000, 13'h0123, 13'h0002, 13'h0003, 13'h1FFF, 16'h0123, 12'h40C};
        tbl[9]  = '{16'hAC00, 13'h0123, 13'h0002, 13'h0003, 13'h1FFF, 16'h2002, 12'h40C};
        tbl[10] = '{16'h0000, 13'h0123, 13'h0002, 13'h0003, 13'h1FFF, 16'h4003, 12'h40C};

        rst = 1'b1; cs_n = 1'b1; sclk = 1'b1; din = 1'b0;
        for (int c = 0; c < 4; c++) ch[c] = '0;
        model_reset();
        cyc(3);
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_oe", 32'(dout_oe), 32'h0);
        check("reset_ctrl", 32'(ctrl_reg), 32'h0);
        check("reset_pulses", 32'({frame_done, frame_err}), 32'h0);
        rst = 1'b0;
        cyc(5);

        for (int i = 0; i < 11; i++) begin
            ch[0] = tbl[i].c0; ch[1] = tbl[i].c1; ch[2] = tbl[i].c2; ch[3] = tbl[i].c3;
            predict(exp_w);
`ifndef AD7324_EMU_NOISE_EN
            exp_w = tbl[i].exp_word;
`endif
            run_frame(tbl[i].din, 16, 1'b0, w, nd, ne, ok);
            model_commit(tbl[i].din);
            check($sformatf("tbl%0d_word", i), 32'(w), 32'(exp_w));
            check($sformatf("tbl%0d_ctrl", i), 32'(ctrl_reg), 32'(tbl[i].exp_ctrl));
            check($sformatf("tbl%0d_done_err", i), 32'({nd[7:0], ne[7:0]}), 32'h0100);
            check($sformatf("tbl%0d_oe", i), 32'({ok, dout_oe}), 32'h2);
        end

        // Abort after 7 falls carrying a control write: nothing may change.
        predict(exp_w);
        run_frame(16'h8C00, 7, 1'b0, w, nd, ne, ok);
        check("abort_err_done", 32'({nd[7:0], ne[7:0]}), 32'h0001);
        check("abort_ctrl", 32'(ctrl_reg), 32'(m_ctrl));
        predict(exp_w);
        run_frame(16'h0000, 16, 1'b0, w, nd, ne, ok);
        model_commit(16'h0000);
        check("post_abort_word", 32'(w), 32'(exp_w));
        check("post_abort_done", 32'({nd[7:0], ne[7:0]}), 32'h0100);

        // Move pointer away from 0, then reset in the middle of a frame.
        run_frame(16'h8A00, 16, 1'b0, w, nd, ne, ok);
        cs_n = 1'b0;
        cyc(8);
        for (int i = 0; i < 3; i++) begin
            din = 1'b1; cyc(8); sclk = 1'b0; cyc(8); sclk = 1'b1;
        end
        cyc(2);
        rst = 1'b1;
        cyc(1);
        check("midrst_oe", 32'(dout_oe), 32'h0);
        check("midrst_ctrl_dout", 32'({ctrl_reg, dout}), 32'h0);
        cs_n = 1'b1; sclk = 1'b1; din = 1'b0;
        cyc(2);
        rst = 1'b0;
        model_reset();
        cyc(5);
        ch[0] = 13'h1ABC; ch[1] = 13'h0111; ch[2] = 13'h0222; ch[3] = 13'h0333;
        predict(exp_w);
        run_frame(16'h0000, 16, 1'b0, w, nd, ne, ok);
        model_commit(16'h0000);
        check("midrst_next_word", 32'(w), 32'(exp_w));
        check("midrst_next_is_ch0", 32'(w[14:13]), 32'h0);

        // Random frames, channels re-randomised mid-frame on some of them.
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < 4; c++) ch[c] = 13'($urandom);
            if ($urandom_range(0, 2) == 0) d = {3'b100, 12'($urandom), 1'($urandom)};
            else                           d = 16'($urandom);
            predict(exp_w);
            run_frame(d, 16, 1'($urandom), w, nd, ne, ok);
            model_commit(d);
            check($sformatf("rnd%0d_word", i), 32'(w), 32'(exp_w));
            check($sformatf("rnd%0d_ctrl", i), 32'(ctrl_reg), 32'(m_ctrl));
            check($sformatf("rnd%0d_done_err", i), 32'({nd[7:0], ne[7:0]}), 32'h0100);
        end

`ifdef AD7324_EMU_NOISE_EN
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        model_reset();
        cyc(5);
        ch[0] = 13'h0FFF;
        for (int i = 0; i < 32; i++) begin
            predict(exp_w);
            run_frame(16'h0000, 16, 1'b0, w, nd, ne, ok);
            model_commit(16'h0000);
            check($sformatf("noise%0d_word", i), 32'(w), 32'(exp_w));
            check($sformatf("noise%0d_range", i),
                  32'(w[12:0] >= 13'h0FFD && w[12:0] <= 13'h0FFF), 32'h1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ad7324_emulator.md
Name: ad7324_emulator

Overview:
- SPI responder that emulates the AD7324 4-channel 13-bit ADC: the target end of the bus our spi_ad7324 master drives.
- Used for hardware-in-the-loop and simulation of the closed-loop controller without the analog front end.
- Channel values (Vout, Temp, Vin, Iout) are supplied as 13-bit two's-complement ports. The block decodes control-register writes from DIN and returns AD7324-format words on DOUT.
- Sits on the GPIO_0 pins in place of the ADC.

Parameters:
- FRAME_BITS, 16, bits per CS frame.
- DATA_W, 13, conversion width (two's complement).
- SYNC_STAGES, 2, synchroniser depth on SCLK/CS_N/DIN.

Ports:
- CLK20M  in  1  system clock, 20 MHz.
- RSTp  in  1  reset; asynchronous, active-high.
- SCLK  in  1  SPI clock from the master; idles high.
- CS_N  in  1  chip select, active-low.
- DIN  in  1  serial data from the master.
- DOUT  out  1  serial data to the master.
- DOUT_OE  out  1  high while DOUT is driven (CS_N low); the pad is tri-stated otherwise.
- CH0_DATA..CH3_DATA  in  13 each  channel values (Vout, Temp, Vin, Iout).
- CTRL_REG  out  12  current control register.
- FRAME_DONE  out  1  one-cycle pulse after a complete frame.
- FRAME_ERR  out  1  one-cycle pulse when CS_N rises before FRAME_BITS SCLK falls.

Behaviour:
- **Clocking and reset**
  - One clock, CLK20M. RSTp is asynchronous and active-high.
  - Reset values: DOUT=0, DOUT_OE=0, CTRL_REG=0, channel pointer=0, bit counter=0, FRAME_DONE=0, FRAME_ERR=0, state=IDLE.
- **Input synchronisation**
  - SCLK, CS_N and DIN pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised copies.
  - Requirement on the master: SCLK high and low phases each ≥5 CLK20M cycles (SCLK ≤2 MHz).
  - Latency from a pin edge to the DOUT update is ≤ SYNC_STAGES+2 cycles.
- **State IDLE**
  - DOUT_OE=0.
  - On CS_N fall:
    - capture the shift word {1'b0, ptr[1:0], CHptr_DATA};
    - drive bit 15 on DOUT, set DOUT_OE=1;
    - clear the counter, go to SHIFT.
- **State SHIFT** (action on each SCLK fall):
  - sample DIN into the receive shift register, MSB first;
  - increment the counter;
  - shift the transmit word left and present the next bit on DOUT.
  - When the counter reaches FRAME_BITS, go to DONE. After the 16th fall DOUT=0.
- **State DONE**
  - Further SCLK edges are ignored.
  - On CS_N rise:
    - pulse FRAME_DONE;
    - apply the register update and pointer update;
    - set DOUT_OE=0, go to IDLE.
- **Abort**
  - CS_N rise while in SHIFT: pulse FRAME_ERR, go to IDLE.
  - No register write and no pointer change.
- **DIN decode** (complete frame only)
  - DIN[15]=WRITE, DIN[14:13]=REG_SEL.
  - If WRITE=1 and REG_SEL=00: CTRL_REG ← DIN[12:1]. Otherwise the write is ignored.
  - ADD = CTRL_REG[10:9] (DIN[11:10]); SEQ = CTRL_REG[3:2] (DIN[4:3]).
- **Pointer update** (after a complete frame)
  - Control write with SEQ=11: ptr←0.
  - Control write with any other SEQ: ptr←new ADD.
  - No write and SEQ=11: ptr ← (ptr==ADD) ? 0 : ptr+1.
  - Otherwise: ptr unchanged.
  - SEQ values 01 and 10 behave as 00.
- **Pipelining**
  - The channel converted in frame N is the one selected after frame N−1, matching the real device.
  - A channel value is sampled once, at the CS_N fall; changes during the frame do not affect it.
- **Edge cases**
  - CS_N rise and SCLK fall detected in the same cycle: the CS_N rise wins and the SCLK fall is discarded.
  - RSTp asserted mid-frame: immediate return to reset values; the frame is lost.

Optional Feature:
- Macro: AD7324_EMU_NOISE_EN.
- When defined:
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per frame at CS_N fall;
  - LFSR[1:0], read as signed (−2..+1), is added to the captured channel value;
  - the sum saturates to −4096..+4095.
- When undefined: the LFSR is absent and the value is returned exactly.

Decomposition:
- Shared package ad7324_pkg holds:
  - constants: FRAME_BITS, DATA_W, REG_SEL_CTRL=2'b00, SEQ_CONT=2'b11;
  - ADD/SEQ bit-index constants;
  - state encodings IDLE=0, SHIFT=1, DONE=2 (2-bit);
  - the LFSR seed.
- Sub-module spi_edge_sync: synchroniser plus rise/fall detector, instantiated three times. Everything else stays in ad7324_emulator.

Test Plan:
- Reset, then a frame with DIN=0, CH0=13'h0123 → DOUT word 16'h0123; FRAME_DONE pulses; CTRL_REG=0.
- Write DIN=16'h8C00 (ADD=3, SEQ=00), then next frame with CH3=13'h1FFF → second word 16'h7FFF; ptr stays 3 on the third frame.
- Write ADD=2, SEQ=11 (DIN=16'h8818), then 4 frames → channel IDs 0,1,2,0.
- CS_N rise after 7 SCLK falls carrying a write → FRAME_ERR pulses; CTRL_REG and ptr unchanged; next frame is normal.
- RSTp asserted mid-frame → DOUT_OE=0 and ptr=0 within 1 cycle; next frame returns CH0.
- With AD7324_EMU_NOISE_EN: CH0=13'h0FFF over 32 frames → every value within 0x0FFD..0x0FFF; saturation observed; sequence matches a reference LFSR from seed ACE1.
